// File: rtl/caxi4interconnect_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// caxi4interconnect_ram_fifo_ctrl
//
// Valid/ready FIFO controller in front of an external dual-port RAM that has a
// synchronous write port and an asynchronous read port. The controller owns
// both RAM ports and drives them from its write and read pointers. A one-entry
// output register sits between the RAM read data and the consumer. Total
// capacity is therefore MEM_DEPTH + 1 entries.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous reset, active-high (priority over flush_i)
//   flush_i          synchronous clear of all contents
//   s_valid_i        producer data valid
//   s_ready_o        controller can accept (registered)
//   s_data_i         producer payload
//   m_valid_o        output register holds data (registered)
//   m_ready_i        consumer accepts
//   m_data_o         output register payload (registered)
//   level_o          entries held = RAM occupancy + m_valid_o
//   almost_full_o    registered, level_o >= AFULL_THRESH
//   ram_wr_en_o      RAM write enable
//   ram_wr_addr_o    RAM write address (write pointer)
//   ram_data_in_o    RAM write data (s_data_i, combinational)
//   ram_rd_addr_o    RAM read address (read pointer)
//   ram_data_out_i   RAM read data (asynchronous read)
// ----------------------------------------------------------------------------
module caxi4interconnect_ram_fifo_ctrl #(
  parameter int unsigned MEM_DEPTH    = 1024,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned AFULL_THRESH = 1020
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,

  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,

  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,

  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  almost_full_o,

  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_in_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_out_i
);

  localparam logic [ADDR_WIDTH-1:0] LastPtr  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AfullLvl = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  s_ready_q, s_ready_d;
  logic                  almost_full_q, almost_full_d;
  logic [ADDR_WIDTH:0]   level_d;

  logic wr_fire;
  logic ld;

  // Handshakes. ld uses the registered RAM count, so a word written at an
  // edge cannot be read at that same edge: no write-to-read bypass needed.
  assign wr_fire = s_valid_i & s_ready_q;
  assign ld      = (ram_count_q != '0) & (~m_valid_q | m_ready_i);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ram_count_d   = ram_count_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;

    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end

    if (ld) begin
      rd_ptr_d  = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      m_valid_d = 1'b1;
      m_data_d  = ram_data_out_i;
    end else if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end

    unique case ({wr_fire, ld})
      2'b10:   ram_count_d = ram_count_q + 1'b1;
      2'b01:   ram_count_d = ram_count_q - 1'b1;
      default: ram_count_d = ram_count_q;
    endcase

    // Flush discards anything that handshook in this cycle as well.
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      m_valid_d   = 1'b0;
    end

    // s_ready depends only on next-state registers, never on m_ready_i
    // combinationally; a pop while full re-opens s_ready one cycle later.
    s_ready_d     = (ram_count_d < DepthCnt) & ~flush_i;
    level_d       = ram_count_d + (ADDR_WIDTH + 1)'(m_valid_d);
    almost_full_d = (level_d >= AfullLvl);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_count_q   <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      s_ready_q     <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_count_q   <= ram_count_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      s_ready_q     <= s_ready_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign s_ready_o     = s_ready_q;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign level_o       = ram_count_q + (ADDR_WIDTH + 1)'(m_valid_q);
  assign almost_full_o = almost_full_q;

  assign ram_wr_en_o   = wr_fire;
  assign ram_wr_addr_o = wr_ptr_q;
  assign ram_data_in_o = s_data_i;
  assign ram_rd_addr_o = rd_ptr_q;

endmodule

// File: tb/tb_caxi4interconnect_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for caxi4interconnect_ram_fifo_ctrl. Two instances with small RAM
// models: dut_a (depth 4, almost-full at 3) for directed fill/drain/flush and
// reset cases, dut_b (depth 5, non power of two) for a wrapping stream with a
// random consumer.
// ----------------------------------------------------------------------------
module tb_caxi4interconnect_ram_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: MEM_DEPTH=4, ADDR_WIDTH=2, AFULL_THRESH=3
  logic       a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic [7:0] a_s_data, a_m_data, a_din, a_dout;
  logic [2:0] a_level;
  logic       a_af, a_wr_en;
  logic [1:0] a_wr_addr, a_rd_addr;
  logic [7:0] mem_a [0:3];

  // Instance B: MEM_DEPTH=5, ADDR_WIDTH=3, AFULL_THRESH=6
  logic       b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic [7:0] b_s_data, b_m_data, b_din, b_dout;
  logic [3:0] b_level;
  logic       b_af, b_wr_en;
  logic [2:0] b_wr_addr, b_rd_addr;
  logic [7:0] mem_b [0:7];

  caxi4interconnect_ram_fifo_ctrl #(
    .MEM_DEPTH(4), .ADDR_WIDTH(2), .DATA_WIDTH(8), .AFULL_THRESH(3)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .s_valid_i(a_s_valid), .s_ready_o(a_s_ready), .s_data_i(a_s_data),
    .m_valid_o(a_m_valid), .m_ready_i(a_m_ready), .m_data_o(a_m_data),
    .level_o(a_level), .almost_full_o(a_af),
    .ram_wr_en_o(a_wr_en), .ram_wr_addr_o(a_wr_addr), .ram_data_in_o(a_din),
    .ram_rd_addr_o(a_rd_addr), .ram_data_out_i(a_dout)
  );

  caxi4interconnect_ram_fifo_ctrl #(
    .MEM_DEPTH(5), .ADDR_WIDTH(3), .DATA_WIDTH(8), .AFULL_THRESH(6)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .s_data_i(b_s_data),
    .m_valid_o(b_m_valid), .m_ready_i(b_m_ready), .m_data_o(b_m_data),
    .level_o(b_level), .almost_full_o(b_af),
    .ram_wr_en_o(b_wr_en), .ram_wr_addr_o(b_wr_addr), .ram_data_in_o(b_din),
    .ram_rd_addr_o(b_rd_addr), .ram_data_out_i(b_dout)
  );

  // RAM models: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (a_wr_en) mem_a[a_wr_addr] <= a_din;
    if (b_wr_en) mem_b[b_wr_addr] <= b_din;
  end
  assign a_dout = mem_a[a_rd_addr];
  assign b_dout = mem_b[b_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int lvl      = 0;       // model of instance A level
  logic [7:0] exp_q[$];   // model of instance A contents, in order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of instance A with scoreboard, level and almost_full checks.
  task automatic cycle_a();
    #1;
    if (a_m_valid && a_m_ready) begin
      check("a_pop_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("a_pop_data", 32'(a_m_data), 32'(exp_q.pop_front()));
      lvl--;
    end
    if (a_s_valid && a_s_ready) begin
      exp_q.push_back(a_s_data);
      lvl++;
    end
    tick();
    check("a_level", 32'(a_level), 32'(lvl));
    check("a_almost_full", 32'(a_af), 32'(lvl >= 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int sent;
    int rcvd;
    logic flag;

    rst = 1'b1;
    a_flush = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0; a_s_data = '0;
    b_flush = 1'b0; b_s_valid = 1'b0; b_m_ready = 1'b0; b_s_data = '0;
    repeat (3) tick();

    // Reset state
    check("rst_s_ready", 32'(a_s_ready), 0);
    check("rst_m_valid", 32'(a_m_valid), 0);
    check("rst_m_data", 32'(a_m_data), 0);
    check("rst_level", 32'(a_level), 0);
    check("rst_af", 32'(a_af), 0);
    rst = 1'b0;
    #1 check("rst_s_ready_low_after_release", 32'(a_s_ready), 0);
    tick();
    check("rst_s_ready_rise", 32'(a_s_ready), 1);

    // Fill with consumer stalled: 5 accepts, RAM holds 22..55, m_data 11
    i = 0;
    for (int c = 0; c < 10; c++) begin
      a_s_valid = 1'b1;
      a_s_data  = 8'(8'h11 * (i + 1));
      flag      = a_s_ready;
      cycle_a();
      if (flag) i++;
    end
    check("full_accepts", 32'(i), 5);
    check("full_s_ready", 32'(a_s_ready), 0);
    check("full_level", 32'(a_level), 5);
    check("full_m_valid", 32'(a_m_valid), 1);
    check("full_m_data_held", 32'(a_m_data), 32'h11);
    check("ram_0", 32'(mem_a[0]), 32'h55);
    check("ram_1", 32'(mem_a[1]), 32'h22);
    check("ram_2", 32'(mem_a[2]), 32'h33);
    check("ram_3", 32'(mem_a[3]), 32'h44);

    // Consumer pops while full; s_ready returns one cycle after first pop
    a_m_ready = 1'b1;
    cycle_a();
    check("pop_s_ready_back", 32'(a_s_ready), 1);
    i = 0;
    for (int c = 0; c < 6; c++) begin
      a_s_data = 8'(8'h66 + 8'h11 * i);
      flag = a_s_ready;
      check("stream_m_valid", 32'(a_m_valid), 1);
      cycle_a();
      if (flag) i++;
    end
    a_s_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle_a();
    check("drain_empty", 32'(exp_q.size()), 0);
    check("drain_m_valid", 32'(a_m_valid), 0);

    // Single write: m_valid one edge after the write edge
    a_m_ready = 1'b0;
    a_s_valid = 1'b1;
    a_s_data  = 8'hA5;
    cycle_a();
    a_s_valid = 1'b0;
    check("single_m_valid_k", 32'(a_m_valid), 0);
    cycle_a();
    check("single_m_valid_k1", 32'(a_m_valid), 1);
    check("single_m_data", 32'(a_m_data), 32'hA5);
    a_m_ready = 1'b1;
    cycle_a();
    check("single_pop_m_valid", 32'(a_m_valid), 0);

    // Flush with 3 held words and concurrent handshakes
    a_m_ready = 1'b0;
    a_s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_s_data = 8'(8'hC1 + c);
      cycle_a();
    end
    a_s_valid = 1'b0;
    cycle_a();
    check("pre_flush_m_valid", 32'(a_m_valid), 1);
    a_flush = 1'b1; a_s_valid = 1'b1; a_s_data = 8'hEE; a_m_ready = 1'b1;
    tick();
    a_flush = 1'b0; a_s_valid = 1'b0;
    lvl = 0;
    exp_q.delete();
    #1;
    check("flush_level", 32'(a_level), 0);
    check("flush_m_valid", 32'(a_m_valid), 0);
    check("flush_s_ready", 32'(a_s_ready), 0);
    check("flush_af", 32'(a_af), 0);
    check("flush_wr_addr", 32'(a_wr_addr), 0);
    check("flush_rd_addr", 32'(a_rd_addr), 0);
    tick();
    check("flush_s_ready_back", 32'(a_s_ready), 1);
    for (int c = 0; c < 3; c++) begin
      check("flush_no_stale", 32'(a_m_valid), 0);
      cycle_a();
    end
    a_s_valid = 1'b1;
    a_s_data  = 8'h5A;
    cycle_a();
    a_s_valid = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) cycle_a();
    check("post_flush_drained", 32'(exp_q.size()), 0);

    // Reset mid-operation drops stored data
    a_m_ready = 1'b0;
    a_s_valid = 1'b1;
    a_s_data  = 8'h77;
    cycle_a();
    cycle_a();
    a_s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lvl = 0;
    exp_q.delete();
    check("rst_mid_level", 32'(a_level), 0);
    check("rst_mid_m_valid", 32'(a_m_valid), 0);
    check("rst_mid_m_data", 32'(a_m_data), 0);
    check("rst_mid_s_ready", 32'(a_s_ready), 0);
    tick();
    check("rst_mid_s_ready_back", 32'(a_s_ready), 1);

    // Depth 5 stream: write address wraps 0..4, output is exactly 0..19
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 400 && rcvd < 20; c++) begin
      b_s_valid = (sent < 20);
      b_s_data  = 8'(sent);
      b_m_ready = 1'($urandom_range(0, 1));
      #1;
      if (b_s_valid && b_s_ready) begin
        check("b_wr_addr", 32'(b_wr_addr), 32'(sent % 5));
        check("b_wr_en", 32'(b_wr_en), 1);
        sent++;
      end
      if (b_m_valid && b_m_ready) begin
        check("b_data", 32'(b_m_data), 32'(rcvd));
        rcvd++;
      end
      tick();
    end
    b_s_valid = 1'b0;
    b_m_ready = 1'b0;
    check("b_received", 32'(rcvd), 20);
    check("b_level_end", 32'(b_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
